// File: rtl/sseg_pkg.sv
// Shared types and the hex-to-segment table for the seven-segment scan driver.
package sseg_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_e;

  // Active-high segment patterns, bit order {g,f,e,d,c,b,a}, indexed by nibble.
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] hex_to_seg(logic [3:0] nibble);
    return SEG_LUT[nibble];
  endfunction

endpackage

// File: rtl/sseg_decoder.sv
// Combinational hex nibble to active-high seven-segment pattern.
module sseg_decoder
  import sseg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  // Pure table lookup; polarity is applied by the caller.
  always_comb begin
    seg_o = hex_to_seg(nibble_i);
  end

endmodule

// File: rtl/sseg_scan_mux.sv
// Time-multiplexed common-anode seven-segment driver with a blanking gap
// between digits. Every pin comes straight from a flop.
module sseg_scan_mux
  import sseg_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int BLANK_CYCLES = 2,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tick,
  input  logic [4*DIGITS-1:0]   digits,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_in,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_done
);

  localparam int IDX_W = $clog2(DIGITS);
  localparam int CNT_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0] AN_OFF   = {DIGITS{ACTIVE_LOW}};
  localparam logic [6:0]        SEG_OFF  = {7{ACTIVE_LOW}};
  localparam logic [DIGITS-1:0] AN_ONE   = {{(DIGITS-1){1'b0}}, 1'b1};

  if (DIGITS < 2 || DIGITS > 8) begin : gBadDigits
    $fatal(1, "sseg_scan_mux: DIGITS must be within 2..8");
  end
  if (BLANK_CYCLES < 1) begin : gBadBlank
    $fatal(1, "sseg_scan_mux: BLANK_CYCLES must be at least 1");
  end

  scan_state_e       state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [IDX_W-1:0]  idx_q;
  logic [3:0]        snapNibble_q;
  logic              snapDp_q;
  logic              snapBlank_q;
  logic [DIGITS-1:0] an_q;
  logic [6:0]        seg_q;
  logic              dp_q;
  logic              frameDone_q;

  logic [3:0]        nibble_d;
  logic              dpReq_d;
  logic              dark_d;
  logic [6:0]        decSeg;
  logic [6:0]        litSeg_d;
  logic              litDp_d;
  logic [DIGITS-1:0] anHot_d;
  logic [IDX_W-1:0]  idxNext_d;

  // While blanking, look at the live inputs so they can be captured on the
  // way into SHOW; while showing, only the captured snapshot matters.
  always_comb begin
    nibble_d = snapNibble_q;
    dpReq_d  = snapDp_q;
    dark_d   = snapBlank_q;
    if (state_q == BLANK) begin
      nibble_d = digits[{idx_q, 2'b00} +: 4];
      dpReq_d  = dp_in[idx_q];
      dark_d   = blank_in[idx_q];
    end
  end

  sseg_decoder uDecoder (
    .nibble_i (nibble_d),
    .seg_o    (decSeg)
  );

  // Active-high pin values for the digit being shown, plus the next index.
  always_comb begin
    litSeg_d  = dark_d ? 7'h00 : decSeg;
    litDp_d   = dpReq_d & ~dark_d;
    anHot_d   = AN_ONE << idx_q;
    idxNext_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
  end

  // Scan FSM with registered pins: blank for BLANK_CYCLES, then show until tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= BLANK;
      cnt_q        <= '0;
      idx_q        <= '0;
      snapNibble_q <= '0;
      snapDp_q     <= 1'b0;
      snapBlank_q  <= 1'b0;
      an_q         <= AN_OFF;
      seg_q        <= SEG_OFF;
      dp_q         <= ACTIVE_LOW;
      frameDone_q  <= 1'b0;
    end else begin
      frameDone_q <= 1'b0;
      case (state_q)
        BLANK: begin
          an_q  <= AN_OFF;
          seg_q <= SEG_OFF;
          dp_q  <= ACTIVE_LOW;
          if (cnt_q == CNT_LAST) begin
            state_q      <= SHOW;
            cnt_q        <= '0;
            snapNibble_q <= nibble_d;
            snapDp_q     <= dpReq_d;
            snapBlank_q  <= dark_d;
            an_q         <= anHot_d ^ AN_OFF;
            seg_q        <= litSeg_d ^ SEG_OFF;
            dp_q         <= litDp_d ^ ACTIVE_LOW;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        SHOW: begin
          if (tick) begin
            state_q     <= BLANK;
            idx_q       <= idxNext_d;
            frameDone_q <= (idx_q == IDX_LAST);
            an_q        <= AN_OFF;
            seg_q       <= SEG_OFF;
            dp_q        <= ACTIVE_LOW;
          end else begin
            an_q  <= anHot_d ^ AN_OFF;
            seg_q <= litSeg_d ^ SEG_OFF;
            dp_q  <= litDp_d ^ ACTIVE_LOW;
          end
        end
        default: begin
          state_q <= BLANK;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = frameDone_q;

endmodule

// File: tb/tb_sseg_scan_mux.sv
// Directed plus randomized bench for sseg_scan_mux against a timeline model.
module tb_sseg_scan_mux;

  localparam int DIGITS = 4;
  localparam int BC     = 2;

  localparam logic [6:0] LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic                  clk;
  logic                  rst_n;
  logic                  tick;
  logic [4*DIGITS-1:0]   digits;
  logic [DIGITS-1:0]     dp_in;
  logic [DIGITS-1:0]     blank_in;
  logic [DIGITS-1:0]     an;
  logic [6:0]            seg;
  logic                  dp;
  logic                  frame_done;

  int checks;
  int failures;
  string curTest;

  // Timeline model: darkLeft counts remaining all-off cycles; while zero the
  // digit captured at the moment it became visible is lit.
  int   darkLeft;
  int   mIdx;
  logic [3:0] shNib;
  logic shDp;
  logic shBlank;
  logic mFrame;

  sseg_scan_mux #(
    .DIGITS       (DIGITS),
    .BLANK_CYCLES (BC),
    .ACTIVE_LOW   (1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .digits     (digits),
    .dp_in      (dp_in),
    .blank_in   (blank_in),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s_%s observed=%0h expected=%0h", curTest, tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] d, input logic [3:0] dpv, input logic [3:0] bl, input logic t);
    digits   = d;
    dp_in    = dpv;
    blank_in = bl;
    tick     = t;
  endtask

  function automatic void modelReset();
    darkLeft = BC;
    mIdx     = 0;
    mFrame   = 1'b0;
    shNib    = 4'h0;
    shDp     = 1'b0;
    shBlank  = 1'b0;
  endfunction

  function automatic void modelStep();
    mFrame = 1'b0;
    if (darkLeft > 0) begin
      darkLeft--;
      if (darkLeft == 0) begin
        shNib   = 4'((digits >> (4 * mIdx)) & 16'hF);
        shDp    = dp_in[mIdx];
        shBlank = blank_in[mIdx];
      end
    end else if (tick) begin
      darkLeft = BC;
      mFrame   = (mIdx == DIGITS - 1);
      mIdx     = (mIdx + 1) % DIGITS;
    end
  endfunction

  task automatic checkModel();
    logic [3:0] eAn;
    logic [6:0] eSeg;
    logic       eDp;
    if (darkLeft > 0) begin
      eAn  = 4'hF;
      eSeg = 7'h7F;
      eDp  = 1'b1;
    end else begin
      eAn  = ~(4'b0001 << mIdx);
      eSeg = shBlank ? 7'h7F : ~LUT[shNib];
      eDp  = !(shDp && !shBlank);
    end
    checkOutput("an", 32'(an), 32'(eAn));
    checkOutput("seg", 32'(seg), 32'(eSeg));
    checkOutput("dp", 32'(dp), 32'(eDp));
    checkOutput("frame", 32'(frame_done), 32'(mFrame));
    checkOutput("onehot", 32'($countones(~an) <= 1), 32'd1);
  endtask

  task automatic stepCycle();
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkModel();
  endtask

  initial begin
    int frameCount;
    int waitCount;
    checks   = 0;
    failures = 0;
    curTest  = "reset";
    rst_n    = 1'b0;
    applyStimulus(16'h1234, 4'b0000, 4'b0000, 1'b0);
    modelReset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("an", 32'(an), 32'hF);
    checkOutput("seg", 32'(seg), 32'h7F);
    checkOutput("dp", 32'(dp), 32'h1);
    checkOutput("frame", 32'(frame_done), 32'h0);
    rst_n = 1'b1;

    // Idle after reset: digit 0 appears on the third cycle without a tick.
    curTest = "idle";
    #1 checkModel();
    stepCycle();
    checkOutput("c2_an", 32'(an), 32'hF);
    stepCycle();
    checkOutput("c3_an", 32'(an), 32'b1110);
    checkOutput("c3_seg", 32'(seg), 32'h19);
    repeat (4) stepCycle();
    checkOutput("hold_an", 32'(an), 32'b1110);

    // Periodic tick: one frame_done per four ticks.
    curTest    = "cafe";
    frameCount = 0;
    applyStimulus(16'hCAFE, 4'b0100, 4'b0000, 1'b0);
    for (int i = 0; i < 81; i++) begin
      tick = (i % 10 == 9);
      stepCycle();
      if (frame_done) frameCount++;
    end
    checkOutput("frames", 32'(frameCount), 32'd2);

    // Blanked digit keeps its anode but shows nothing.
    curTest = "blank";
    applyStimulus(16'h0007, 4'b0000, 4'b1000, 1'b0);
    for (int i = 0; i < 45; i++) begin
      tick = (i % 9 == 8);
      stepCycle();
    end

    // Inputs changing mid-show must not disturb the lit digit.
    curTest = "midchg";
    applyStimulus(16'h1111, 4'b0000, 4'b0000, 1'b0);
    for (int i = 0; i < 40; i++) begin
      tick = (i % 8 == 7);
      if (i % 8 == 4) digits = (digits == 16'h1111) ? 16'h8888 : 16'h1111;
      stepCycle();
    end

    // Tick held high: one lit cycle per digit in a BC+1 period.
    curTest = "tickhi";
    tick = 1'b1;
    for (int i = 0; i < 20; i++) stepCycle();
    tick = 1'b0;

    // Asynchronous reset while digit 2 is being shown.
    curTest   = "areset";
    waitCount = 0;
    while (!(darkLeft == 0 && mIdx == 2) && waitCount < 50) begin
      tick = (darkLeft == 0);
      stepCycle();
      waitCount++;
    end
    tick = 1'b0;
    checkOutput("reach_d2", 32'(darkLeft == 0 && mIdx == 2), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_an", 32'(an), 32'hF);
    checkOutput("async_seg", 32'(seg), 32'h7F);
    checkOutput("async_dp", 32'(dp), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();
    #1 checkModel();
    stepCycle();
    stepCycle();
    checkOutput("restart_an", 32'(an), 32'b1110);

    // Randomized traffic.
    curTest = "random";
    for (int i = 0; i < 400; i++) begin
      applyStimulus(16'($urandom), 4'($urandom), 4'($urandom_range(0, 15) < 3 ? $urandom : 0),
                    ($urandom_range(0, 3) == 0));
      if (i % 150 == 149) begin
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 checkOutput("rnd_reset_an", 32'(an), 32'hF);
        @(negedge clk);
        rst_n = 1'b1;
        modelReset();
      end
      stepCycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
